// File: rtl/wb_periph_pkg.sv
// Shared types and constants for the Wishbone peripheral controller.
// WB_PERIPH_STATUS_EN adds an internal status slave just above the external select bits.
package wb_periph_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DERR = 2'd2,
        ST_TERR = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_DECODE  = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    localparam int ERRCNT_W  = 8;
    localparam int LASTADR_W = 16;

`ifdef WB_PERIPH_STATUS_EN
    localparam int STATUS_SLV = 1;
`else
    localparam int STATUS_SLV = 0;
`endif

    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/wb_onehot_decode.sv
// Slave-select field decode: valid only when exactly one bit is set.
// Produces the gated one-hot select and a binary index for the read-data mux.
module wb_onehot_decode
    import wb_periph_pkg::*;
#(
    parameter int W  = 3,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  f_i,
    output logic          valid_o,
    output logic [W-1:0]  sel_o,
    output logic [IW-1:0] idx_o
);

    assign valid_o = is_onehot(32'(f_i));
    assign sel_o   = valid_o ? f_i : '0;

    always_comb begin
        idx_o = '0;
        for (int k = 0; k < W; k++) begin
            if (f_i[k]) idx_o = IW'(k);
        end
    end

endmodule

// File: rtl/wb_periph_ctrl.sv
// Wishbone classic peripheral controller: one-hot slave select, ACK/data muxing, ACK watchdog.
// Build option WB_PERIPH_STATUS_EN adds a status slave (errcnt, cause, last faulting address).
module wb_periph_ctrl
    import wb_periph_pkg::*;
#(
    parameter int NSLV    = 3,
    parameter int SLVBIT0 = 2,
    parameter int TOWIDTH = 8,
    parameter int TIMEOUT = 200
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              STB_I,
    input  logic              WE_I,
    input  logic [31:0]       ADR_I,
    input  logic [31:0]       DAT_I,
    output logic              ACK_O,
    output logic [31:0]       DAT_O,
    output logic [NSLV-1:0]   s_STB_O,
    input  logic [NSLV-1:0]   s_ACK_I,
    input  logic [32*NSLV-1:0] s_DAT_I,
    input  logic              clr_err_i,
    output logic              buserr_o
);

    localparam int FW = NSLV + STATUS_SLV;
    localparam int IW = (FW > 1) ? $clog2(FW) : 1;

    state_t               state_q;
    logic [TOWIDTH-1:0]   cnt_q;
    logic                 buserr_q, buserr_d;

    logic [FW-1:0]        f;
    logic                 f_valid;
    logic [FW-1:0]        f_sel;
    logic [IW-1:0]        f_idx;
    logic                 active, req, err_cyc, ack_hit, stat_wr;
    logic [31:0]          rd_dat;
    logic                 unused_bits;

    assign f = ADR_I[SLVBIT0 +: FW];

    wb_onehot_decode #(.W(FW), .IW(IW)) u_dec (
        .f_i    (f),
        .valid_o(f_valid),
        .sel_o  (f_sel),
        .idx_o  (f_idx)
    );

    // Reset gates the bus outputs directly so they drop without waiting for a clock.
    assign active  = ~RST_I & ((state_q == ST_IDLE) | (state_q == ST_WAIT));
    assign err_cyc = ~RST_I & ((state_q == ST_DERR) | (state_q == ST_TERR));
    assign req     = active & STB_I & f_valid;
    assign s_STB_O = req ? f_sel[NSLV-1:0] : '0;

`ifdef WB_PERIPH_STATUS_EN
    logic                  stat_sel;
    logic [ERRCNT_W-1:0]   errcnt_q;
    logic [1:0]            cause_q;
    logic [LASTADR_W-1:0]  lastadr_q;
    logic [31:0]           status_word;

    assign stat_sel    = req & f_sel[NSLV];
    assign stat_wr     = stat_sel & WE_I;
    assign ack_hit     = (|(s_ACK_I & s_STB_O)) | stat_sel;
    assign status_word = {errcnt_q, 6'b0, cause_q, lastadr_q};

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            errcnt_q  <= '0;
            cause_q   <= CAUSE_NONE;
            lastadr_q <= '0;
        end else if (err_cyc) begin
            if (errcnt_q != '1) errcnt_q <= errcnt_q + 1'b1;
            cause_q   <= (state_q == ST_TERR) ? CAUSE_TIMEOUT : CAUSE_DECODE;
            lastadr_q <= ADR_I[LASTADR_W-1:0];
        end else if (stat_wr) begin
            errcnt_q  <= '0;
            cause_q   <= CAUSE_NONE;
            lastadr_q <= '0;
        end
    end
`else
    assign stat_wr = 1'b0;
    assign ack_hit = |(s_ACK_I & s_STB_O);
`endif

    assign ACK_O = ack_hit | err_cyc;

    always_comb begin
        rd_dat = '0;
        if (req) begin
            for (int k = 0; k < NSLV; k++) begin
                if (f_idx == IW'(k)) rd_dat = s_DAT_I[32*k +: 32];
            end
`ifdef WB_PERIPH_STATUS_EN
            if (f_idx == IW'(NSLV)) rd_dat = status_word;
`endif
        end
    end
    assign DAT_O = rd_dat;

    // A terminating error outranks a same-cycle clear so firmware never misses it.
    always_comb begin
        buserr_d = buserr_q;
        if (err_cyc)
            buserr_d = 1'b1;
        else if (clr_err_i | stat_wr)
            buserr_d = 1'b0;
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            buserr_q <= 1'b0;
        end else begin
            buserr_q <= buserr_d;
            case (state_q)
                ST_IDLE: begin
                    if (STB_I) begin
                        if (!f_valid) begin
                            state_q <= ST_DERR;
                        end else if (!ack_hit) begin
                            state_q <= ST_WAIT;
                            cnt_q   <= TOWIDTH'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (!STB_I || ack_hit) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == TOWIDTH'(TIMEOUT - 1)) begin
                        state_q <= ST_TERR;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign buserr_o    = buserr_q;
    assign unused_bits = ^{ADR_I, DAT_I, WE_I};

endmodule
